// File: rtl/gpr_read_unit.sv
// gpr_read_unit
// General-purpose register file for the NPC core: one write port, two
// registered operand read ports with write-to-read bypass, and a handshaked
// dump stream that walks every entry in address order for the difftest bridge.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   wen, waddr, wdata           write port (writeback)
//   ren, raddr1, raddr2         operand read request (decode)
//   rdata1, rdata2, rvalid      registered operand data, one-cycle valid pulse
//   dump_req                    start a full-file dump (sampled in IDLE only)
//   dump_valid, dump_ready      dump beat handshake
//   dump_addr, dump_data        current beat address and data
//   dump_last                   current beat is the final entry
//   dump_busy                   dump FSM not IDLE
//   dump_done                   one-cycle pulse after the final beat is accepted
//
// Dump FSM
//   state | meaning
//   IDLE  | no dump in progress, waiting for dump_req
//   SEND  | beat at ptr presented on dump_*, waiting for dump_ready

module gpr_read_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rvalid,
    input  logic                  dump_req,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_last,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_nxt;

    // Value a reader sees this cycle: hardwired zero, then same-cycle write
    // bypass, then the stored entry.
    function automatic logic [DATA_WIDTH-1:0] eff(input logic [ADDR_WIDTH-1:0] a);
        if (ZERO_REG && (a == '0)) begin
            return '0;
        end else if (wen && (waddr == a)) begin
            return wdata;
        end else begin
            return rf[a];
        end
    endfunction

    assign ptr_nxt   = ptr + ADDR_WIDTH'(1);
    assign dump_addr = ptr;

    // Storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wen && !(ZERO_REG && (waddr == '0))) begin
            rf[waddr] <= wdata;
        end
    end

    // Operand read ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1 <= '0;
            rdata2 <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= ren;
            if (ren) begin
                rdata1 <= eff(raddr1);
                rdata2 <= eff(raddr2);
            end
        end
    end

    // Dump FSM. dump_data is a snapshot taken when the beat is loaded, so a
    // write to the address currently on offer cannot disturb a stalled beat,
    // while entries ahead of the pointer still pick up later writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            dump_data  <= '0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        state      <= SEND;
                        ptr        <= '0;
                        dump_data  <= eff('0);
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                        dump_last  <= 1'b0;
                    end
                end
                SEND: begin
                    // dump_valid is always high in SEND, so ready alone
                    // completes the handshake.
                    if (dump_ready) begin
                        if (dump_last) begin
                            state      <= IDLE;
                            dump_valid <= 1'b0;
                            dump_busy  <= 1'b0;
                            dump_last  <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            ptr       <= ptr_nxt;
                            dump_data <= eff(ptr_nxt);
                            dump_last <= (ptr_nxt == LAST_ADDR);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gpr_read_unit.md
# gpr_read_unit

General-purpose register file for the NPC core with read access. It keeps the existing single write port and adds two synchronous operand read ports with write-to-read bypass. It also adds a handshaked dump stream that walks every register in address order for the difftest checker. It sits between decode (read ports), writeback (write port) and the simulation-side difftest bridge (dump stream).

## Interface
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes
- One clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wen  in  1  write enable
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data
- ren  in  1  read request for both operand ports
- raddr1, raddr2  in  ADDR_WIDTH  operand read addresses
- rdata1, rdata2  out  DATA_WIDTH  registered operand data
- rvalid  out  1  one-cycle pulse: rdata1/rdata2 updated this cycle
- dump_req  in  1  start a full-file dump
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts beat
- dump_addr  out  ADDR_WIDTH  address of current beat
- dump_data  out  DATA_WIDTH  data of current beat
- dump_last  out  1  current beat is the final entry (addr = 2**ADDR_WIDTH-1)
- dump_busy  out  1  dump FSM not IDLE
- dump_done  out  1  one-cycle pulse after final beat accepted

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops. All entries are cleared to 0 by reset.
- Write: at the clock edge, if wen and not (ZERO_REG and waddr==0), then rf[waddr] <= wdata.
- Effective read value for address a, eff(a):
  - 0 if ZERO_REG and a==0;
  - otherwise wdata if wen and waddr==a (same-cycle bypass);
  - otherwise rf[a].
- Read ports: on an edge with ren=1, rdata1 <= eff(raddr1), rdata2 <= eff(raddr2), rvalid <= 1. With ren=0, rdata1/rdata2 hold their values and rvalid <= 0.
- Dump FSM has two states, IDLE and SEND. An internal pointer ptr is ADDR_WIDTH bits.
  - IDLE:
    - dump_req=1 → go to SEND with ptr=0 and dump_data <= eff(0).
    - dump_req is sampled only in IDLE.
  - SEND:
    - dump_valid=1, dump_addr=ptr, dump_last=(ptr==all-ones).
    - On handshake (dump_valid and dump_ready) with dump_last=0: ptr <= ptr+1 and dump_data <= eff(ptr+1).
    - On handshake with dump_last=1: go to IDLE and pulse dump_done.
    - If no handshake, dump_addr and dump_data are held stable. A write to the held address does not change the beat in flight.
  - dump_busy = (state != IDLE).
- Writes and operand reads are fully independent of the dump. An entry not yet loaded into dump_data reflects any writes made before it is loaded.
- ptr never wraps: the dump ends at the last entry.

## Timing
- Reset values: rdata1=rdata2=0, rvalid=0, dump_valid=0, dump_addr=0, dump_data=0, dump_last=0, dump_busy=0, dump_done=0, state=IDLE.
- Reset takes effect immediately, with no clock required. Asserting reset mid-dump aborts the dump without a dump_done pulse.
- Read latency: ren in cycle N → rdata valid and rvalid=1 in cycle N+1.
- Write → read: a write in cycle N is visible to a read issued in cycle N through the bypass, so there is no hazard bubble.
- Dump:
  - dump_req in cycle N → dump_valid=1 in cycle N+1 with entry 0.
  - With dump_ready held high, the dump produces one beat per cycle, 2**ADDR_WIDTH beats in total.
  - dump_done=1 and dump_valid=0 in the cycle after the last handshake.
  - A new dump_req is accepted in that same dump_done cycle, so the next dump_valid rises one cycle later.
- dump_ready may toggle arbitrarily. The consumer sees no duplicated and no skipped address.

## Test plan
- Reset and zero register:
  - Stimulus: release rst_n, then write 32'hDEADBEEF to x0, then ren with raddr1=0.
  - Required: rdata1=0 and rvalid=1 exactly one cycle after ren.
- Bypass:
  - Stimulus: in the same cycle, wen with waddr=5, wdata=32'h1234 and ren with raddr1=5, raddr2=6 (x6 holds 32'h77).
  - Required: next cycle rdata1=32'h1234, rdata2=32'h77.
- Full dump with dump_ready=1:
  - Stimulus: preload rf[i]=i*4 for i=1..31, then issue dump_req.
  - Required: 32 consecutive beats with addr 0..31 and data 0,4,...,124; dump_last only on addr 31; dump_done one cycle after the last beat.
- Backpressure:
  - Stimulus: during a dump, hold dump_ready=0 for 3 cycles at addr 7 and write rf[7]=32'hAA during the stall.
  - Required: beat 7 keeps its old data; beat 8 follows; no skip and no duplicate.
- Write ahead of pointer:
  - Stimulus: during a dump at addr 3, write rf[20]=32'h55.
  - Required: beat 20 carries 32'h55.
- Reset mid-dump:
  - Stimulus: assert rst_n=0 asynchronously at beat 10.
  - Required: dump_valid, dump_busy and rdata drop to 0 immediately; no dump_done pulse; a subsequent dump_req restarts at addr 0 with all data 0.
